// File: rtl/gf2_min_weight_solver.sv
// gf2_min_weight_solver: takes a reduced row-echelon augmented GF(2) matrix [A|b],
// locates pivot and free columns, enumerates every free-variable assignment one per
// cycle, back-substitutes the pivots and reports the minimum Hamming weight of x.
// Optional macro GF2_MIN_WEIGHT_SOLUTION_EN adds the 'solution' output port.
module gf2_min_weight_solver #(
  parameter int MAX_ROWS   = 16,
  parameter int MAX_COLS   = 16,
  parameter int MAX_FREE   = 8,
  parameter int MAX_ROWS_W = ($clog2(MAX_ROWS + 1) < 1) ? 1 : $clog2(MAX_ROWS + 1),
  parameter int MAX_COLS_W = ($clog2(MAX_COLS + 1) < 1) ? 1 : $clog2(MAX_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAX_ROWS_W-1:0] rows,
  input  logic [MAX_COLS_W-1:0] cols,
  input  logic                  start,
  input  logic [MAX_COLS-1:0]   RREF [MAX_ROWS],
  output logic                  ready,
  output logic                  solvable,
  output logic                  overflow,
  output logic [MAX_COLS_W-1:0] min_weight,
  output logic                  busy
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
  ,
  output logic [MAX_COLS-1:0]   solution
`endif
);

  localparam int IDX_W = ($clog2(MAX_ROWS) < 1) ? 1 : $clog2(MAX_ROWS);
  localparam int K_W   = MAX_FREE + 1;
  localparam logic [MAX_ROWS_W-1:0] ROW_ONE = 1;
  localparam logic [K_W-1:0]        K_ONE   = 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_CLASSIFY = 3'd2;
  localparam logic [2:0] S_ENUM     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Columns 0..c-1 occupy the top c bits; everything right of the RHS is dropped.
  function automatic logic [MAX_COLS-1:0] f_col_mask(input logic [MAX_COLS_W-1:0] c);
    logic [MAX_COLS:0] s;
    s = {(MAX_COLS + 1){1'b1}} << (MAX_COLS - int'(c));
    return s[MAX_COLS-1:0];
  endfunction

  // The RHS is logical column c-1, i.e. bit MAX_COLS-c.
  function automatic logic [MAX_COLS-1:0] f_rhs_bit(input logic [MAX_COLS_W-1:0] c);
    logic [MAX_COLS:0] s;
    s = {{MAX_COLS{1'b0}}, 1'b1} << (MAX_COLS - int'(c));
    return s[MAX_COLS-1:0];
  endfunction

  logic [2:0]                         r_state;
  logic [MAX_ROWS_W-1:0]              r_rows;
  logic [MAX_ROWS_W-1:0]              r_row;
  logic [MAX_COLS_W-1:0]              r_cols;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  r_mat;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  r_piv_oh;
  logic [MAX_ROWS-1:0]                r_piv_vld;
  logic [MAX_COLS-1:0]                r_pivot_mask;
  logic [MAX_COLS-1:0]                r_free_mask;
  logic [MAX_COLS_W-1:0]              r_nfree;
  logic                               r_incons;
  logic                               r_ovf;
  logic [K_W-1:0]                     r_k;
  logic [MAX_COLS_W-1:0]              r_best;
  logic                               r_ready;
  logic                               r_solvable;
  logic                               r_overflow;
  logic [MAX_COLS_W-1:0]              r_min_weight;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
  logic [MAX_COLS-1:0]                r_best_x;
  logic [MAX_COLS-1:0]                r_solution;
`endif

  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  w_cap;
  logic [MAX_COLS-1:0]                w_cap_mask;
  logic [MAX_COLS-1:0]                w_var_mask;
  logic [MAX_COLS-1:0]                w_rhs_bit;
  logic [MAX_COLS-1:0]                w_scan_row;
  logic [MAX_COLS-1:0]                w_scan_vars;
  logic                               w_scan_rhs;
  logic [MAX_COLS-1:0]                w_scan_oh;
  logic [MAX_COLS-1:0]                w_free_mask;
  logic [MAX_COLS_W-1:0]              w_nfree;
  logic [MAX_COLS-1:0]                w_free_assign;
  logic [MAX_COLS-1:0]                w_x;
  logic [MAX_COLS_W-1:0]              w_w;
  logic                               w_k_last;

  assign w_rhs_bit   = f_rhs_bit(r_cols);
  assign w_var_mask  = f_col_mask(r_cols) & ~w_rhs_bit;
  assign w_scan_row  = r_mat[r_row[IDX_W-1:0]];
  assign w_scan_vars = w_scan_row & w_var_mask;
  assign w_scan_rhs  = |(w_scan_row & w_rhs_bit);
  assign w_free_mask = w_var_mask & ~r_pivot_mask;
  assign w_nfree     = MAX_COLS_W'($countones(w_free_mask));
  assign w_w         = MAX_COLS_W'($countones(w_x));
  assign w_k_last    = (r_k == ((K_ONE << r_nfree) - K_ONE));

  // Capture mask: rows past the valid count and bits right of the RHS read as zero.
  always_comb begin
    w_cap_mask = f_col_mask(cols);
    w_cap      = '0;
    for (int r = 0; r < MAX_ROWS; r++)
      if (r < int'(rows)) w_cap[r] = RREF[r] & w_cap_mask;
  end

  // Pivot of the scanned row is its leftmost (highest-bit) set variable column.
  always_comb begin
    w_scan_oh = '0;
    for (int i = 0; i < MAX_COLS; i++)
      if (w_scan_vars[i]) begin
        w_scan_oh    = '0;
        w_scan_oh[i] = 1'b1;
      end
  end

  // Spread bit i of k onto the i-th free column, counting from column 0 (MSB) down.
  always_comb begin
    int             n;
    logic [K_W-1:0] kshift;
    n             = 0;
    kshift        = '0;
    w_free_assign = '0;
    for (int b = MAX_COLS - 1; b >= 0; b--)
      if (r_free_mask[b]) begin
        kshift           = r_k >> n;
        w_free_assign[b] = kshift[0];
        n++;
      end
  end

  // Back-substitute every pivot in parallel: x_p = rhs XOR parity(row & free assignment).
  always_comb begin
    w_x = w_free_assign;
    for (int r = 0; r < MAX_ROWS; r++)
      if (r_piv_vld[r] &&
          ((^(r_mat[r] & w_var_mask & w_free_assign)) != (|(r_mat[r] & w_rhs_bit))))
        w_x = w_x | r_piv_oh[r];
  end

  // Control FSM: IDLE -> SCAN -> CLASSIFY -> ENUM -> DONE, with result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rows       <= '0;
      r_row        <= '0;
      r_cols       <= '0;
      r_mat        <= '0;
      r_piv_oh     <= '0;
      r_piv_vld    <= '0;
      r_pivot_mask <= '0;
      r_free_mask  <= '0;
      r_nfree      <= '0;
      r_incons     <= 1'b0;
      r_ovf        <= 1'b0;
      r_k          <= '0;
      r_best       <= '0;
      r_ready      <= 1'b0;
      r_solvable   <= 1'b0;
      r_overflow   <= 1'b0;
      r_min_weight <= '0;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
      r_best_x     <= '0;
      r_solution   <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows       <= rows;
            r_cols       <= cols;
            r_mat        <= w_cap;
            r_piv_vld    <= '0;
            r_pivot_mask <= '0;
            r_nfree      <= '0;
            r_incons     <= 1'b0;
            r_ovf        <= 1'b0;
            r_row        <= '0;
            r_state      <= (rows == '0) ? S_CLASSIFY : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_scan_vars == '0) begin
            if (w_scan_rhs) r_incons <= 1'b1;
          end else begin
            r_piv_vld[r_row[IDX_W-1:0]] <= 1'b1;
            r_piv_oh[r_row[IDX_W-1:0]]  <= w_scan_oh;
            r_pivot_mask                <= r_pivot_mask | w_scan_oh;
          end
          r_row <= r_row + ROW_ONE;
          if ((r_row + ROW_ONE) == r_rows) r_state <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          r_free_mask <= w_free_mask;
          r_nfree     <= w_nfree;
          r_best      <= '1;
          r_k         <= '0;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
          r_best_x    <= '0;
`endif
          if (r_incons) begin
            r_state <= S_DONE;
          end else if (int'(w_nfree) > MAX_FREE) begin
            r_ovf   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ENUM;
          end
        end
        S_ENUM: begin
          // Strict compare: ties keep the earliest assignment.
          if (w_w < r_best) begin
            r_best   <= w_w;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
            r_best_x <= w_x;
`endif
          end
          if (w_k_last) r_state <= S_DONE;
          else          r_k     <= r_k + K_ONE;
        end
        S_DONE: begin
          r_ready      <= 1'b1;
          r_solvable   <= !r_incons && !r_ovf;
          r_overflow   <= r_ovf;
          r_min_weight <= (!r_incons && !r_ovf) ? r_best : '0;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
          r_solution   <= (!r_incons && !r_ovf) ? r_best_x : '0;
`endif
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready      = r_ready;
  assign solvable   = r_solvable;
  assign overflow   = r_overflow;
  assign min_weight = r_min_weight;
  assign busy       = (r_state != S_IDLE);
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
  assign solution   = r_solution;
`endif

endmodule

// File: tb/tb_gf2_min_weight_solver.sv
// Testbench for gf2_min_weight_solver: directed cases plus randomized RREF systems
// compared against a brute-force minimum-weight search over all assignments.
module tb_gf2_min_weight_solver;

  localparam int MR = 16;
  localparam int MC = 16;
  localparam int MF = 3;
  localparam int RW = 5;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [RW-1:0] rows;
  logic [CW-1:0] cols;
  logic [MC-1:0] RREF [MR];
  logic          ready;
  logic          solvable;
  logic          overflow;
  logic [CW-1:0] min_weight;
  logic          busy;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
  logic [MC-1:0] solution;
`endif

  int checks = 0;
  int errors = 0;

  gf2_min_weight_solver #(
    .MAX_ROWS(MR), .MAX_COLS(MC), .MAX_FREE(MF)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .start(start), .RREF(RREF),
    .ready(ready), .solvable(solvable), .overflow(overflow),
    .min_weight(min_weight), .busy(busy)
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
    , .solution(solution)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nr;
    int          nc;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    bit          solv;
    bit          ovf;
    int          mw;
    int          lat;
    logic [15:0] sol;
  } dcase_t;

  // Brute force: try every x over the variables, keep the lightest consistent one.
  function automatic void ref_model(input int nr, input int nc, input logic [15:0] m [16],
                                    output bit solv, output bit ovf, output int mw,
                                    output int nenum);
    int nv, rank, best, nfree, p;
    bit ok, nz;
    logic [15:0] row;
    nv   = nc - 1;
    rank = 0;
    for (int r = 0; r < nr; r++) begin
      row = m[r];
      nz  = 0;
      for (int j = 0; j < nv; j++) if (row[15-j]) nz = 1;
      if (nz) rank++;
    end
    nfree = nv - rank;
    best  = -1;
    for (int x = 0; x < (1 << nv); x++) begin
      ok = 1;
      for (int r = 0; r < nr; r++) begin
        row = m[r];
        p   = 0;
        for (int j = 0; j < nv; j++) if (((x >> j) & 1) == 1 && row[15-j]) p ^= 1;
        if (p != int'(row[16-nc])) ok = 0;
      end
      if (ok && (best < 0 || $countones(x) < best)) best = $countones(x);
    end
    solv  = (best >= 0) && (nfree <= MF);
    ovf   = (best >= 0) && (nfree > MF);
    mw    = solv ? best : 0;
    nenum = solv ? (1 << nfree) : 0;
  endfunction

  // Issue one start and count clock edges until ready (bounded).
  task automatic run_case(input int nr, input int nc, input logic [15:0] m [16], output int lat);
    @(negedge clk);
    rows = RW'(nr);
    cols = CW'(nc);
    for (int i = 0; i < 16; i++) RREF[i] = m[i];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (solvable !== 1'b0) begin errors++; $display("FAIL reset_solvable: got %b want 0", solvable); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (min_weight !== '0) begin errors++; $display("FAIL reset_min_weight: got %0d want 0", min_weight); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
    checks++; if (solution !== '0) begin errors++; $display("FAIL reset_solution: got %h want 0", solution); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    dcase_t      tbl [8];
    logic [15:0] m [16];
    int          lat;
    tbl[0] = '{3, 4, 16'h9000, 16'h5000, 16'h3000, 1'b1, 1'b0, 3, 6, 16'hE000};
    tbl[1] = '{2, 4, 16'hB000, 16'h6000, 16'h0000, 1'b1, 1'b0, 1, 6, 16'h8000};
    tbl[2] = '{2, 3, 16'h8000, 16'h2000, 16'h0000, 1'b0, 1'b0, 0, 4, 16'h0000};
    tbl[3] = '{1, 6, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 3, 16'h0000};
    tbl[4] = '{2, 3, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 8, 16'h0000};
    tbl[5] = '{0, 4, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 10, 16'h0000};
    tbl[6] = '{3, 4, 16'h9ABC, 16'h5123, 16'h3FFF, 1'b1, 1'b0, 3, 6, 16'hE000};
    tbl[7] = '{2, 6, 16'h8000, 16'h0400, 16'h0000, 1'b0, 1'b0, 0, 4, 16'h0000};
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) m[i] = 16'hFFFF;
      if (tbl[t].nr > 0) m[0] = tbl[t].r0;
      if (tbl[t].nr > 1) m[1] = tbl[t].r1;
      if (tbl[t].nr > 2) m[2] = tbl[t].r2;
      run_case(tbl[t].nr, tbl[t].nc, m, lat);
      checks++; if (lat != tbl[t].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", t, lat, tbl[t].lat); end
      checks++; if (solvable !== tbl[t].solv) begin errors++; $display("FAIL dir%0d_solvable: got %b want %b", t, solvable, tbl[t].solv); end
      checks++; if (overflow !== tbl[t].ovf) begin errors++; $display("FAIL dir%0d_overflow: got %b want %b", t, overflow, tbl[t].ovf); end
      checks++; if (min_weight !== CW'(tbl[t].mw)) begin errors++; $display("FAIL dir%0d_min_weight: got %0d want %0d", t, min_weight, tbl[t].mw); end
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
      checks++; if (solution !== tbl[t].sol) begin errors++; $display("FAIL dir%0d_solution: got %h want %h", t, solution, tbl[t].sol); end
`endif
      @(posedge clk);
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dir%0d_ready_pulse: got %b want 0", t, ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_after: got %b want 0", t, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    rows = RW'(3);
    cols = CW'(4);
    for (int i = 0; i < 16; i++) RREF[i] = 16'h0000;
    RREF[0] = 16'h9000; RREF[1] = 16'h5000; RREF[2] = 16'h3000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    // A second start while busy (with an inconsistent system) must be ignored.
    @(negedge clk);
    rows = RW'(2);
    cols = CW'(3);
    RREF[0] = 16'h8000; RREF[1] = 16'h2000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_run: got %b want 1", busy); end
    while (ready !== 1'b1 && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    checks++; if (solvable !== 1'b1) begin errors++; $display("FAIL ignore_solvable: got %b want 1", solvable); end
    checks++; if (min_weight !== CW'(3)) begin errors++; $display("FAIL ignore_min_weight: got %0d want 3", min_weight); end
  endtask

  task automatic test_reset_mid_enum();
    logic [15:0] m [16];
    int          seen;
    int          lat;
    @(negedge clk);
    rows = RW'(0);
    cols = CW'(4);
    for (int i = 0; i < 16; i++) RREF[i] = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (solvable !== 1'b0) begin errors++; $display("FAIL midrst_solvable: got %b want 0", solvable); end
    checks++; if (min_weight !== '0) begin errors++; $display("FAIL midrst_min_weight: got %0d want 0", min_weight); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 if (ready === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_ready: got %0d pulses want 0", seen); end
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    m[0] = 16'h9000; m[1] = 16'h5000; m[2] = 16'h3000;
    run_case(3, 4, m, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL midrst_rerun_latency: got %0d want 6", lat); end
    checks++; if (solvable !== 1'b1) begin errors++; $display("FAIL midrst_rerun_solvable: got %b want 1", solvable); end
    checks++; if (min_weight !== CW'(3)) begin errors++; $display("FAIL midrst_rerun_min_weight: got %0d want 3", min_weight); end
  endtask

  task automatic test_random();
    logic [15:0] m [16];
    logic [15:0] low;
    int          pc [16];
    bit          isp [16];
    int          nr, nc, nv, rank, lat, mw, nenum;
    bit          solv, ovf;
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
    logic [15:0] row;
    int          p;
    bit          good;
`endif
    for (int it = 0; it < 60; it++) begin
      nr   = $urandom_range(0, 6);
      nc   = $urandom_range(2, 9);
      nv   = nc - 1;
      rank = 0;
      for (int i = 0; i < 16; i++) begin
        isp[i] = 0;
        pc[i]  = 0;
        m[i]   = 16'($urandom);
      end
      for (int j = 0; j < nv; j++)
        if (rank < nr && $urandom_range(0, 1) == 1) begin
          pc[rank] = j;
          isp[j]   = 1;
          rank++;
        end
      low = 16'((1 << (16 - nc)) - 1);
      for (int i = 0; i < nr; i++) begin
        m[i] = m[i] & low;
        if (i < rank) begin
          m[i][15-pc[i]] = 1'b1;
          for (int j = pc[i] + 1; j < nv; j++)
            if (!isp[j]) m[i][15-j] = 1'($urandom_range(0, 1));
          m[i][16-nc] = 1'($urandom_range(0, 1));
        end else begin
          m[i][16-nc] = ($urandom_range(0, 3) == 0);
        end
      end
      ref_model(nr, nc, m, solv, ovf, mw, nenum);
      run_case(nr, nc, m, lat);
      checks++; if (lat != nr + 2 + nenum) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, nr + 2 + nenum); end
      checks++; if (solvable !== solv) begin errors++; $display("FAIL rnd%0d_solvable: got %b want %b", it, solvable, solv); end
      checks++; if (overflow !== ovf) begin errors++; $display("FAIL rnd%0d_overflow: got %b want %b", it, overflow, ovf); end
      checks++; if (min_weight !== CW'(mw)) begin errors++; $display("FAIL rnd%0d_min_weight: got %0d want %0d", it, min_weight, mw); end
`ifdef GF2_MIN_WEIGHT_SOLUTION_EN
      good = 1;
      if (solv) begin
        if ((solution & low) != 16'h0 || solution[16-nc] != 1'b0) good = 0;
        if ($countones(solution) != mw) good = 0;
        for (int r = 0; r < nr; r++) begin
          row = m[r];
          p   = 0;
          for (int j = 0; j < nv; j++) if (row[15-j] && solution[15-j]) p ^= 1;
          if (p != int'(row[16-nc])) good = 0;
        end
      end else if (solution !== 16'h0) begin
        good = 0;
      end
      checks++; if (!good) begin errors++; $display("FAIL rnd%0d_solution: got %h (min weight %0d)", it, solution, mw); end
`endif
      @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rows  = '0;
    cols  = '0;
    for (int i = 0; i < MR; i++) RREF[i] = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_enum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
